// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access widths, FSM states and
// the width-to-byte-count helper used by the range check.
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_RSVD = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load-data extender: selects the low byte/half/word of the
// raw memory word and zero- or sign-extends it to 32 bits.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] raw_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = raw_i;
        case (size_i)
            SIZE_BYTE: result_o = {{24{~unsigned_i & raw_i[7]}}, raw_i[7:0]};
            SIZE_HALF: result_o = {{16{~unsigned_i & raw_i[15]}}, raw_i[15:0]};
            default:   result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accept in IDLE, one memory cycle in
// ACCESS, one-cycle response pulse in RESP. Faulting requests skip ACCESS.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'd16384
) (
    input  logic        clk,
    input  logic        rst,
    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready never depends on req_valid.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_range,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_storex,
    input  logic [31:0] mem_readdata,
    output lsu_state_t  dbg_state_o
);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        store_q, store_d;
    logic        unsigned_q, unsigned_d;
    logic        misalign_q, misalign_d;
    logic        range_q, range_d;

    logic        req_misalign;
    logic        req_range;
    logic [32:0] req_end;
    logic [31:0] ext_result;

    // 33-bit end address so a request near 2^32 cannot wrap below the limit.
    assign req_end      = {1'b0, req_addr} + {30'b0, size_bytes(req_size)};
    assign req_misalign = (req_size == SIZE_RSVD)
                        | ((req_size == SIZE_HALF) & req_addr[0])
                        | ((req_size == SIZE_WORD) & (|req_addr[1:0]));
    assign req_range    = ~req_misalign & (req_end > {1'b0, ADDR_LIMIT});

    load_extend u_load_extend (
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .raw_i      (mem_readdata),
        .result_o   (ext_result)
    );

    assign req_ready = (state_q == ST_IDLE) & ~rst;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        size_d     = size_q;
        store_d    = store_q;
        unsigned_d = unsigned_q;
        misalign_d = misalign_q;
        range_d    = range_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    store_d    = req_is_store;
                    unsigned_d = req_unsigned;
                    rdata_d    = '0;
                    misalign_d = req_misalign;
                    range_d    = req_range;
                    state_d    = (req_misalign || req_range) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rdata_d = store_q ? 32'd0 : ext_result;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= '0;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            misalign_q <= 1'b0;
            range_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            size_q     <= size_d;
            store_q    <= store_d;
            unsigned_q <= unsigned_d;
            misalign_q <= misalign_d;
            range_q    <= range_d;
        end
    end

    assign resp_valid    = (state_q == ST_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_misalign = misalign_q;
    assign resp_range    = range_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign mem_storex    = size_q;
    assign mem_read      = (state_q == ST_ACCESS) & ~store_q;
    assign mem_write     = (state_q == ST_ACCESS) & store_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'd16384, size in bytes of the attached byte-addressed data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  1  CPU presents a load/store request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_is_store  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 11 word, 10 reserved.
REQ-008 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_misalign  output  1  qualified by resp_valid: alignment or reserved-size error.
REQ-014 resp_range  output  1  qualified by resp_valid: access exceeds ADDR_LIMIT.
REQ-015 mem_address  output  32  to memory address.
REQ-016 mem_writedata  output  32  to memory write data.
REQ-017 mem_read  output  1  memory read strobe.
REQ-018 mem_write  output  1  memory write strobe, sampled by memory on clk rising edge.
REQ-019 mem_storex  output  2  memory width select, same encoding as req_size.
REQ-020 mem_readdata  input  32  combinational little-endian read data from memory.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE with rst low.
REQ-022 IDLE: on req_valid && req_ready, register all req_* fields; go to ACCESS if legal, otherwise to RESP with the error flag set.
REQ-023 Legal: size 00 any address; 01 requires addr[0]=0; 11 requires addr[1:0]=0; 10 always illegal (misalign); addr + bytes > ADDR_LIMIT sets resp_range.
REQ-024 Misalign has priority over range; an erroneous request SHALL never assert mem_read or mem_write.
REQ-025 ACCESS lasts exactly one cycle: mem_address = registered addr, mem_storex = registered size, mem_writedata = registered wdata unmodified, with mem_write=1 for stores and mem_read=1 for loads.
REQ-026 Load: at the end of ACCESS capture mem_readdata; byte uses [7:0], half uses [15:0], word uses [31:0]; extend per req_unsigned (ignored for word).
REQ-027 RESP: resp_valid=1 for exactly one cycle with rdata and flags held, then IDLE.
REQ-028 Latency: accept at edge N, ACCESS during cycle N+1, resp_valid during cycle N+2; erroneous requests give resp_valid during cycle N+1; throughput is one request per 3 cycles.
REQ-029 Outside ACCESS: mem_read=0 and mem_write=0; mem_address, mem_writedata and mem_storex hold their last registered values.
REQ-030 Address arithmetic is 33-bit, so addr + bytes cannot wrap past 2^32 undetected.

Reset
REQ-031 With rst high at a clock edge, the unit SHALL enter IDLE and clear all registers.
REQ-032 After reset: resp_valid, resp_rdata, resp_misalign, resp_range, mem_read, mem_write, mem_address, mem_writedata and mem_storex are all 0.
REQ-033 While rst is high, req_ready=0 and requests are ignored.
REQ-034 Reset mid-operation aborts the transaction: no response is produced and no strobe is asserted in the following cycle.

Structure
REQ-035 Shared package holds SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings and the lsu_state_t enum, reused by the memory-side width decoding.
REQ-036 Sub-module load_extend (combinational: size, unsigned, raw data -> 32-bit result) is instantiated once.

Verification
REQ-037 Store word 0x12345678 at 0x100, then load word at 0x100 -> mem_write during one cycle only; load resp_rdata=0x12345678 at N+2.
REQ-038 Store byte 0x80 at 0x203, then load byte signed at 0x203 -> 0xFFFFFF80; same load unsigned -> 0x00000080.
REQ-039 Load half at 0x101 -> resp_misalign=1 at N+1, rdata=0, mem_read never asserted; size 10 at 0x0 -> resp_misalign=1.
REQ-040 Load word at 0x3FFC -> legal; load word at 0x3FFE -> misalign (not range); load byte at 0x4000 -> resp_range=1.
REQ-041 Hold req_valid high continuously with back-to-back requests -> accepts exactly every 3rd cycle; req_ready=0 in ACCESS and RESP.
REQ-042 Assert rst during ACCESS of a store -> next cycle IDLE, mem_write=0, no resp_valid, all outputs 0.
